// File: rtl/st_align_pkg.sv
// Shared definitions for the store-data aligner: size encodings, bank geometry,
// FSM state encoding and the size-to-byte-count decode.
package st_align_pkg;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  localparam int BANK_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2
  } state_e;

  // Highest set size bit wins; an all-zero size is a zero-byte store.
  function automatic logic [3:0] sz2bytes(input logic [3:0] sz);
    if ((sz & SZ_D) != 4'b0)      return 4'd8;
    else if ((sz & SZ_W) != 4'b0) return 4'd4;
    else if ((sz & SZ_H) != 4'b0) return 4'd2;
    else if ((sz & SZ_B) != 4'b0) return 4'd1;
    else                          return 4'd0;
  endfunction

endpackage

// File: rtl/st_align_shf.sv
// Byte-granular left shifter for store data and its byte mask: a 1-byte fine
// stage followed by an 8-position coarse stage in 2-byte steps.
module st_align_shf
  import st_align_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int LWIDTH = 128
) (
  input  logic [DWIDTH-1:0]              data,
  input  logic [3:0]                     nbytes,
  input  logic [3:0]                     off,
  output logic [LWIDTH+DWIDTH-1:0]       w,
  output logic [(LWIDTH+DWIDTH)/8-1:0]   m
);

  localparam int WW = LWIDTH + DWIDTH;
  localparam int MW = WW / 8;
  localparam int DB = DWIDTH / 8;

  logic [WW-1:0] w_base, w_fine;
  logic [MW-1:0] m_base, m_fine;

  // NOTE: every output of this block is assigned a default first, so no
  // path through the loops or conditionals can infer a latch.
  always_comb begin
    w_base = '0;
    m_base = '0;
    // Bytes above the store size are dropped so disabled lanes stay zero.
    for (int i = 0; i < DB; i++) begin
      if (4'(i) < nbytes) begin
        m_base[i]          = 1'b1;
        w_base[i*8 +: 8]   = data[i*8 +: 8];
      end
    end

    w_fine = off[0] ? {w_base[WW-9:0], 8'b0} : w_base;
    m_fine = off[0] ? {m_base[MW-2:0], 1'b0} : m_base;

    w = '0;
    m = '0;
    for (int k = 0; k < BANK_BYTES / 2; k++) begin
      if (off[3:1] == 3'(k)) begin
        w = w_fine << (16 * k);
        m = m_fine << (2 * k);
      end
    end
  end

endmodule

// File: rtl/st_align.sv
// Store-data aligner: places a right-justified store operand into its bank
// lanes and splits bank-crossing stores into two output beats.
module st_align
  import st_align_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int LWIDTH = 128,
  parameter int TAGW   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [DWIDTH-1:0]    in_data,
  input  logic [3:0]           in_sz,
  input  logic [3:0]           in_off,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [LWIDTH-1:0]    out_data,
  output logic [LWIDTH/8-1:0]  out_ben,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_hi,
  output logic                 out_last
);

  localparam int LB = LWIDTH / 8;
  localparam int DB = DWIDTH / 8;

  state_e              state_q, state_d;
  logic [LWIDTH-1:0]   data_q, data_d;
  logic [LB-1:0]       ben_q, ben_d;
  logic [TAGW-1:0]     tag_q, tag_d;
  logic                split_q, split_d;
  logic [DWIDTH-1:0]   hi_data_q, hi_data_d;
  logic [DB-1:0]       hi_ben_q, hi_ben_d;

  logic [3:0]               nbytes;
  logic                     split;
  logic [LWIDTH+DWIDTH-1:0] w;
  logic [LB+DB-1:0]         m;
  logic                     accept;

  assign nbytes = sz2bytes(in_sz);
  assign split  = ({1'b0, in_off} + {1'b0, nbytes}) > 5'd16;

  st_align_shf #(.DWIDTH(DWIDTH), .LWIDTH(LWIDTH)) u_shf (
    .data   (in_data),
    .nbytes (nbytes),
    .off    (in_off),
    .w      (w),
    .m      (m)
  );

  // Ready depends on out_rdy only, never on in_vld; held low during reset.
  assign in_rdy = rst & ((state_q == ST_IDLE) |
                         (out_rdy & ((state_q == ST_B1) |
                                     ((state_q == ST_B0) & ~split_q))));
  assign accept = in_vld & in_rdy;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ben_d     = ben_q;
    tag_d     = tag_q;
    split_d   = split_q;
    hi_data_d = hi_data_q;
    hi_ben_d  = hi_ben_q;

    case (state_q)
      ST_B0: begin
        if (out_rdy) begin
          if (split_q) begin
            state_d           = ST_B1;
            data_d            = '0;
            data_d[DWIDTH-1:0] = hi_data_q;
            ben_d             = '0;
            ben_d[DB-1:0]     = hi_ben_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_B1: if (out_rdy) state_d = ST_IDLE;
      default: ;
    endcase

    // A new request only gets in when the held beat is free, so it overrides.
    if (accept) begin
      state_d   = ST_B0;
      data_d    = w[LWIDTH-1:0];
      ben_d     = m[LB-1:0];
      tag_d     = in_tag;
      split_d   = split;
      hi_data_d = w[LWIDTH+DWIDTH-1:LWIDTH];
      hi_ben_d  = m[LB+DB-1:LB];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the output register is cleared so nothing stale is
  // visible after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      ben_q     <= '0;
      tag_q     <= '0;
      split_q   <= 1'b0;
      hi_data_q <= '0;
      hi_ben_q  <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      ben_q     <= ben_d;
      tag_q     <= tag_d;
      split_q   <= split_d;
      hi_data_q <= hi_data_d;
      hi_ben_q  <= hi_ben_d;
    end
  end

  assign out_vld  = (state_q != ST_IDLE);
  assign out_hi   = (state_q == ST_B1);
  assign out_last = (state_q == ST_B1) | ((state_q == ST_B0) & ~split_q);
  assign out_data = data_q;
  assign out_ben  = ben_q;
  assign out_tag  = tag_q;

endmodule

// File: tb/tb_st_align.sv
// Directed self-checking bench for st_align with hand-computed expectations.
module tb_st_align;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld;
  logic         in_rdy;
  logic [63:0]  in_data;
  logic [3:0]   in_sz;
  logic [3:0]   in_off;
  logic [8:0]   in_tag;
  logic         out_vld;
  logic         out_rdy;
  logic [127:0] out_data;
  logic [15:0]  out_ben;
  logic [8:0]   out_tag;
  logic         out_hi;
  logic         out_last;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  st_align #(.DWIDTH(64), .LWIDTH(128), .TAGW(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .in_sz    (in_sz),
    .in_off   (in_off),
    .in_tag   (in_tag),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_ben  (out_ben),
    .out_tag  (out_tag),
    .out_hi   (out_hi),
    .out_last (out_last)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sz, input logic [3:0] off,
                       input logic [63:0] data, input logic [8:0] tag);
    in_vld  = 1'b1;
    in_sz   = sz;
    in_off  = off;
    in_data = data;
    in_tag  = tag;
  endtask

  // Present one request for exactly one edge; outputs then show beat0.
  task automatic send(input logic [3:0] sz, input logic [3:0] off,
                      input logic [63:0] data, input logic [8:0] tag);
    drive(sz, off, data, tag);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [127:0] data,
                            input logic [15:0] ben, input logic hi, input logic last);
    check({tag, "_vld"},  128'(out_vld),  128'(1'b1));
    check({tag, "_data"}, out_data,       data);
    check({tag, "_ben"},  128'(out_ben),  128'(ben));
    check({tag, "_hi"},   128'(out_hi),   128'(hi));
    check({tag, "_last"}, 128'(out_last), 128'(last));
  endtask

  initial begin
    rst = 1'b0; in_vld = 1'b0; in_sz = '0; in_off = '0; in_data = '0; in_tag = '0;
    out_rdy = 1'b1;
    tick(); tick();

    // Reset state
    check("rst_vld",  128'(out_vld),  128'(0));
    check("rst_hi",   128'(out_hi),   128'(0));
    check("rst_last", 128'(out_last), 128'(0));
    check("rst_data", out_data,       128'(0));
    check("rst_ben",  128'(out_ben),  128'(0));
    check("rst_tag",  128'(out_tag),  128'(0));
    check("rst_rdy",  128'(in_rdy),   128'(0));
    rst = 1'b1;
    #1;
    check("idle_rdy", 128'(in_rdy),   128'(1));

    // Non-split word
    send(4'b0100, 4'd2, 64'hAABBCCDD, 9'h1A5);
    check_beat("word", 128'hAABBCCDD_0000, 16'h003C, 1'b0, 1'b1);
    check("word_tag", 128'(out_tag), 128'(9'h1A5));
    tick();
    check("word_done", 128'(out_vld), 128'(0));

    // Split dword
    send(4'b1000, 4'd12, 64'h1122334455667788, 9'h042);
    check_beat("spl0", {32'h55667788, 96'h0}, 16'hF000, 1'b0, 1'b0);
    check("spl0_rdy", 128'(in_rdy), 128'(0));
    tick();
    check_beat("spl1", 128'h11223344, 16'h000F, 1'b1, 1'b1);
    check("spl1_tag", 128'(out_tag), 128'(9'h042));
    check("spl1_rdy", 128'(in_rdy), 128'(1));
    tick();
    check("spl_done", 128'(out_vld), 128'(0));

    // Backpressure: upper data bytes must be masked off for a byte store
    out_rdy = 1'b0;
    send(4'b0001, 4'd3, 64'hFFFFFFFFFFFFFF5A, 9'h003);
    drive(4'b0010, 4'd6, 64'h000000000000BEEF, 9'h004);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy",  128'(in_rdy),  128'(0));
      check("bp_data", out_data,      128'h5A000000);
      check("bp_ben",  128'(out_ben), 128'(16'h0008));
      check("bp_tag",  128'(out_tag), 128'(9'h003));
      tick();
    end
    out_rdy = 1'b1;
    #1;
    check("bp_rel_rdy", 128'(in_rdy), 128'(1));
    tick();
    in_vld = 1'b0;
    check_beat("bp_b", 128'hBEEF << 48, 16'h00C0, 1'b0, 1'b1);
    check("bp_b_tag", 128'(out_tag), 128'(9'h004));
    tick();
    check("bp_done", 128'(out_vld), 128'(0));

    // Back-to-back byte stores at full throughput
    begin
      logic [3:0]   offs [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
      logic [15:0]  bens [4] = '{16'h0001, 16'h0020, 16'h0400, 16'h8000};
      logic [127:0] dats [4] = '{128'h11, 128'h22 << 40, 128'h33 << 80, 128'h44 << 120};
      logic [7:0]   vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
        drive(4'b0001, offs[i], {56'h0, vals[i]}, 9'(i + 16));
        #1;
        check("b2b_rdy", 128'(in_rdy), 128'(1));
        tick();
        check_beat("b2b", dats[i], bens[i], 1'b0, 1'b1);
        check("b2b_tag", 128'(out_tag), 128'(i + 16));
      end
      in_vld = 1'b0;
      tick();
      check("b2b_done", 128'(out_vld), 128'(0));
    end

    // Reset mid-split drops beat1
    out_rdy = 1'b0;
    send(4'b1000, 4'd12, 64'h1122334455667788, 9'h0AA);
    check("rs_vld",  128'(out_vld),  128'(1));
    check("rs_last", 128'(out_last), 128'(0));
    rst = 1'b0;
    tick();
    check("rs_vld0", 128'(out_vld), 128'(0));
    check("rs_hi0",  128'(out_hi),  128'(0));
    check("rs_ben0", 128'(out_ben), 128'(0));
    rst = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rs_quiet", 128'(out_vld), 128'(0));
    end

    // Edge: off=8 dword fills upper half, no split
    send(4'b1000, 4'd8, 64'h0102030405060708, 9'h011);
    check_beat("e8", {64'h0102030405060708, 64'h0}, 16'hFF00, 1'b0, 1'b1);
    tick();
    check("e8_done", 128'(out_vld), 128'(0));

    // Edge: off=9 dword crosses by one byte
    send(4'b1000, 4'd9, 64'h0102030405060708, 9'h012);
    check_beat("e9a", 128'h02030405060708_000000000000000000, 16'hFE00, 1'b0, 1'b0);
    tick();
    check_beat("e9b", 128'h01, 16'h0001, 1'b1, 1'b1);
    tick();
    check("e9_done", 128'(out_vld), 128'(0));

    // Zero size: single empty beat
    send(4'b0000, 4'd4, 64'hDEADBEEFDEADBEEF, 9'h1FF);
    check_beat("sz0", 128'h0, 16'h0000, 1'b0, 1'b1);
    tick();
    check("sz0_done", 128'(out_vld), 128'(0));

    // Multiple size bits: highest wins (4 bytes)
    send(4'b0110, 4'd0, 64'hCAFEF00D12345678, 9'h007);
    check_beat("szhb", 128'h12345678, 16'h000F, 1'b0, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/st_align.md
Name: st_align

Overview:
- Store-data aligner: the write-direction counterpart of the load-side extract/shift path.
- Takes a right-justified store operand (1/2/4/8 bytes), a byte offset and a tag. Produces bank-aligned 128-bit data plus 16-bit byte enables for the store-merge buffer.
- A store crossing the 16-byte bank boundary is split into two output beats.
- Sits between the AGU/store-data queue and the L1 write-merge stage.

Parameters:
- DWIDTH, 64: store operand width in bits.
- LWIDTH, 128: bank width in bits; LWIDTH/8 byte lanes.
- TAGW, 9: store-queue tag width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-low reset (rst=0 resets on the clk edge).
- in_vld, input, 1: request valid.
- in_rdy, output, 1: aligner can accept a request this cycle.
- in_data, input, DWIDTH: store data, right-justified.
- in_sz, input, 4: size; bit0=1B, bit1=2B, bit2=4B, bit3=8B.
- in_off, input, 4: byte offset within the bank.
- in_tag, input, TAGW: store tag.
- out_vld, output, 1: output beat valid.
- out_rdy, input, 1: consumer accepts the beat.
- out_data, output, LWIDTH: aligned bank data.
- out_ben, output, 16: byte enables.
- out_tag, output, TAGW: tag copied from the request.
- out_hi, output, 1: 0 = addressed bank, 1 = following bank (second beat of a split).
- out_last, output, 1: final beat of this request.

Behaviour:
- Size decode:
  - Byte count N comes from the highest set bit of in_sz.
  - in_sz=0 gives N=0: one beat, out_ben=0, out_data=0.
- Alignment:
  - Form W = zero-extended in_data (192 bits) << (in_off*8).
  - Form M = ((1<<N)-1) << in_off (24 bits).
  - Beat0: out_data=W[127:0], out_ben=M[15:0].
  - Beat1: out_data=W[191:128], out_ben=M[23:16].
  - Disabled byte lanes are always 0 in out_data.
- Split condition: in_off+N > 16.
- FSM states:
  - IDLE: no beat held.
  - B0: beat0 registered.
  - B1: beat1 registered.
- Transitions:
  - IDLE, in_vld&in_rdy → B0. Latch request; register beat0 at the same edge.
  - B0, out_rdy & ~split → IDLE, or → B0 if a new request is accepted in the same cycle.
  - B0, out_rdy & split → B1.
  - B1, out_rdy → IDLE, or → B0 on same-cycle accept.
- in_rdy:
  - = (state==IDLE) | (out_rdy & (state==B1 | (state==B0 & ~split_q))).
  - Combinational from out_rdy; no in_vld→in_rdy path.
- Latency: 1 cycle from accept to out_vld; a split store occupies 2 output cycles. Full throughput for non-split stores.
- out_vld = (state!=IDLE).
- out_hi = (state==B1).
- out_last = (state==B1) | (state==B0 & ~split_q).
- Outputs hold stable while out_vld & ~out_rdy.
- Reset values: state=IDLE, out_vld=0, out_hi=0, out_last=0, out_data=0, out_ben=0, out_tag=0. in_rdy=0 while rst=0.
- Reset mid-split drops the pending beat1; no beat is emitted after reset.
- Boundary cases:
  - in_off=15 with N=1 is not split.
  - in_off=8 with N=8 is not split; out_ben=16'hFF00.
  - in_off=9 with N=8 is split.

Decomposition:
- Shared package:
  - size encoding constants SZ_B/SZ_H/SZ_W/SZ_D.
  - bank byte count localparam (16).
  - FSM state localparams.
  - function sz2bytes.
- One natural sub-module: st_align_shf. Combinational 192-bit data and 24-bit mask left-shifter built as a byte-granular mux (8 coarse positions × 2 fine positions or equivalent). Instantiated once; the FSM and output register sit in st_align.

Test Plan:
- Non-split word: sz=4'b0100, off=2, data=0xAABBCCDD, out_rdy=1 → one beat next cycle: out_ben=16'h003C, out_data[47:16]=0xAABBCCDD, all other bits 0, out_hi=0, out_last=1.
- Split dword: sz=4'b1000, off=12, data=0x1122334455667788 → beat0: out_ben=16'hF000, out_data[127:96]=0x55667788, out_last=0. Beat1: out_hi=1, out_ben=16'h000F, out_data[31:0]=0x11223344, out_last=1. in_rdy=0 during beat0.
- Backpressure: hold out_rdy=0 for 3 cycles with beat0 valid → out_data/out_ben/out_tag stable, in_rdy=0. Release out_rdy → beat proceeds and no request is lost.
- Back-to-back: 4 non-split byte stores at off=0,5,10,15 with out_rdy=1 → 4 consecutive beats with out_ben=0x0001, 0x0020, 0x0400, 0x8000.
- Reset mid-split: assert rst=0 while in B0 of a split store → next cycle out_vld=0, state IDLE, no beat1 emitted after rst=1.
- Edge: off=8, sz=dword → single beat with out_ben=16'hFF00. off=9, sz=dword → split with ben 16'hFE00 then 16'h0001.
